dispatch_unit: RTL
==================

# dispatch_unit

Dual-issue dispatch stage between the decoded-instruction FIFO and the two execute pipes. Each cycle it reads the two head entries of the FIFO and checks register hazards against a 32-entry busy scoreboard and structural rules. It pops 0, 1 or 2 entries through the FIFO's `invalid_en` port and registers the issued instructions into a per-pipe issue stage that holds its contents under back-pressure.

## Interface
Parameters:
- DATA_W, `DECODE_DATA_WIDTH: width of one decoded entry. Minimum 21.
- Entry layout: payload at DATA_W-1:21, opaque and passed through.

Entry field layout (fixed, low bits):
- [0] valid
- [5:1] rd
- [6] rd_we
- [11:7] rs1
- [16:12] rs2
- [17] use_rs1
- [18] use_rs2
- [19] is_mem: memory op, pipe 0 only.
- [20] is_serial: CSR/priv/barrier, must issue alone.

Ports:
- clk  input  1  clock. All state changes on posedge.
- rst  input  1  synchronous, active-low reset. Reset is in effect when rst==0 at a posedge.
- flush  input  1  pipeline flush. Same effect on state as reset.
- fifo_data1  input  DATA_W  FIFO head entry (older).
- fifo_data2  input  DATA_W  FIFO head+1 entry.
- fifo_empty  input  1  FIFO reports no readable entries.
- invalid_en  output  2  pop request to the FIFO. 2'b01 = pop 1, 2'b11 = pop 2.
- ex_ready  input  1  both execute pipes accept the current issue-stage contents.
- wb_en  input  2  writeback port k retires a register write.
- wb_rd0, wb_rd1  input  5  writeback destination per port.
- issue_valid  output  2  bit k: issue slot k holds a valid instruction for pipe k.
- issue_data0, issue_data1  output  DATA_W  issued entries.
- dual_cnt  output  32  count of cycles in which 2 instructions were dispatched.
- stall_cnt  output  32  count of cycles with a FIFO entry present but 0 dispatched.

## Operation
- Presence: entry k is present iff !fifo_empty && fifo_datak[0].
- Accept: the issue stage can take new contents when `adv = !(|issue_valid) || ex_ready`.
- effbusy[r] = busy[r] && !(wb_en[0] && wb_rd0==r) && !(wb_en[1] && wb_rd1==r). Same-cycle writeback bypasses the scoreboard.

Dispatch of entry 1 (go0) requires all of:
- adv
- entry 1 present
- no effbusy on any used source (rs1 when use_rs1, rs2 when use_rs2)

Dispatch of entry 2 (go1) requires all of:
- go0, and entry 2 present
- no effbusy on its used sources
- neither entry is is_serial
- entry 2 is not is_mem
- no RAW on entry 1: entry 1 rd_we and rd!=0 and rd equals a used source of entry 2
- no WAW: both entries have rd_we and the same nonzero rd

Outputs of dispatch:
- invalid_en = {go1, go0}, combinational.
- Forced to 2'b00 during reset, during flush, and when !adv.

Issue stage, on each posedge:
- If adv: issue_valid <= {go1, go0}, issue_data0 <= fifo_data1 and issue_data1 <= fifo_data2, each loaded only when dispatched and otherwise zeroed.
- If !adv: all issue outputs hold.

Scoreboard, busy[31:0]:
- Set at the edge for each dispatched entry with rd_we and rd!=0.
- Cleared for each wb_en port.
- Set wins over clear on the same register in the same cycle.
- busy[0] is always 0.

Counters:
- Saturate at 32'hFFFFFFFF.
- Cleared by reset only; flush does not clear them.

Reset and flush:
- issue_valid=0, issue_data0/1=0, busy=0, invalid_en=0.
- Flush overrides a same-cycle dispatch. No pop occurs and no busy bit is set.

## Timing
- Latency from FIFO head to issue_valid: 1 cycle.
- The pop is visible to the FIFO at the same edge the issue registers load.
- Back-to-back issue is possible every cycle while ex_ready=1.
- A writeback in cycle N unblocks a dependent entry in cycle N (bypass). That entry issues at edge N.
- Under !ex_ready, issue outputs stay bit-stable and no pops occur.
- Reset mid-operation: all outputs reach their reset values at the first edge with rst==0, regardless of ex_ready.

## Test plan
- Independent pair: rd x1 and rd x2, no sources, ex_ready=1 -> invalid_en=2'b11 that cycle. Next cycle: issue_valid=2'b11, busy[1] and busy[2] set, dual_cnt=1.
- RAW inside pair: entry1 writes x5, entry2 uses rs1=x5 -> invalid_en=2'b01, issue_valid=2'b01. Next cycle entry2 (now at the head) stalls until wb_en[0] with wb_rd0=5, then dispatches in that same cycle.
- Structural: entry2 is_mem -> single issue. Entry1 is_serial -> single issue. Two entries both writing x7 -> single issue. Any entry with rd=x0 and rd_we=1 -> dispatches and never sets busy.
- Back-pressure: issue_valid=2'b11 with ex_ready=0 for 3 cycles -> invalid_en=0 and outputs unchanged. stall_cnt increments 3 if FIFO non-empty.
- Flush and reset: busy x3 set, flush asserted with a dispatchable pair -> invalid_en=0, next cycle issue_valid=0 and busy=0. rst=0 mid-stream -> all outputs 0 and counters 0.
- Same-cycle set/clear: wb_rd0=9 retire while a new entry with rd=x9 dispatches -> busy[9]=1 after the edge.

Source files
------------

// File: rtl/dispatch_unit.sv
// Dual-issue dispatch stage: hazard-checks the two FIFO head entries against a
// register busy scoreboard and loads up to two instructions into the issue stage.
module dispatch_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] fifo_data1,
    input  logic [DATA_W-1:0] fifo_data2,
    input  logic              fifo_empty,
    output logic [1:0]        invalid_en,
    input  logic              ex_ready,
    input  logic [1:0]        wb_en,
    input  logic [4:0]        wb_rd0,
    input  logic [4:0]        wb_rd1,
    output logic [1:0]        issue_valid,
    output logic [DATA_W-1:0] issue_data0,
    output logic [DATA_W-1:0] issue_data1,
    output logic [31:0]       dual_cnt,
    output logic [31:0]       stall_cnt
);

    logic [31:0] busy;
    logic [31:0] wb_clr;
    logic [31:0] effbusy;
    logic [31:0] set_mask;
    logic [31:0] busy_nxt;
    logic        pres0, pres1;
    logic        adv;
    logic        raw, waw;
    logic        go0, go1;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (&c) ? c : c + 32'd1;
    endfunction

    function automatic logic [31:0] reg_bit(input logic en, input logic [4:0] r);
        return en ? (32'd1 << r) : 32'd0;
    endfunction

    // An entry's sources are clear when no used source register is still busy.
    function automatic logic src_ok(input logic [DATA_W-1:0] e, input logic [31:0] eb);
        return !(e[17] && eb[e[11:7]]) && !(e[18] && eb[e[16:12]]);
    endfunction

    function automatic logic writes_reg(input logic [DATA_W-1:0] e);
        return e[6] && (e[5:1] != 5'd0);
    endfunction

    always_comb begin
        pres0   = !fifo_empty && fifo_data1[0];
        pres1   = !fifo_empty && fifo_data2[0];
        adv     = !(|issue_valid) || ex_ready;
        wb_clr  = reg_bit(wb_en[0], wb_rd0) | reg_bit(wb_en[1], wb_rd1);
        effbusy = busy & ~wb_clr;

        raw = writes_reg(fifo_data1) &&
              ((fifo_data2[17] && fifo_data2[11:7]  == fifo_data1[5:1]) ||
               (fifo_data2[18] && fifo_data2[16:12] == fifo_data1[5:1]));
        waw = writes_reg(fifo_data1) && writes_reg(fifo_data2) &&
              (fifo_data1[5:1] == fifo_data2[5:1]);

        go0 = adv && pres0 && src_ok(fifo_data1, effbusy);
        go1 = go0 && pres1 && src_ok(fifo_data2, effbusy) &&
              !fifo_data1[20] && !fifo_data2[20] && !fifo_data2[19] && !raw && !waw;

        invalid_en = (rst && !flush) ? {go1, go0} : 2'b00;

        set_mask = reg_bit(invalid_en[0] && writes_reg(fifo_data1), fifo_data1[5:1]) |
                   reg_bit(invalid_en[1] && writes_reg(fifo_data2), fifo_data2[5:1]);
        // Set is applied after the clear so a same-cycle redefinition stays busy.
        busy_nxt = ((busy & ~wb_clr) | set_mask) & ~32'd1;
    end

    // Issue stage boundary: dispatched entries register here for the execute pipes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= '0;
            issue_valid <= '0;
            issue_data0 <= '0;
            issue_data1 <= '0;
            dual_cnt    <= '0;
            stall_cnt   <= '0;
        end else begin
            if (invalid_en == 2'b11)
                dual_cnt <= sat_inc(dual_cnt);
            if ((pres0 || pres1) && invalid_en == 2'b00)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush) begin
                busy        <= '0;
                issue_valid <= '0;
                issue_data0 <= '0;
                issue_data1 <= '0;
            end else begin
                busy <= busy_nxt;
                if (adv) begin
                    issue_valid <= invalid_en;
                    issue_data0 <= invalid_en[0] ? fifo_data1 : '0;
                    issue_data1 <= invalid_en[1] ? fifo_data2 : '0;
                end
            end
        end
    end

endmodule
